// File: rtl/clock_sequencer.sv
// clock_sequencer: qualifies the asynchronous PLL lock, sequences SDRAM clock
// forwarding and core reset release, and generates divided clock enables.
// Latency: pllLocked rising to sysReset low is SYNC_STAGES+1+LOCK_STABLE+SDRAM_WAIT edges.
// Backpressure: none. Lock loss in CKON/RUN drops back to WAIT on the next edge.
//
// Ports:
//   clock      system clock (DCM output)
//   resetn     asynchronous active-low reset
//   pllLocked  raw PLL lock, asynchronous to clock
//   sdramCkD0  ODDR D0 (rising-edge data)
//   sdramCkD1  ODDR D1 (falling-edge data)
//   sysReset   active-high core reset, synchronously deasserted
//   sdramInit  one-cycle pulse on each entry into RUN
//   ce         divided clock enables, active only in RUN
//   state      0 WAIT, 1 STAB, 2 CKON, 3 RUN
//   lossCount  saturating count of lock losses in CKON/RUN
module clock_sequencer #(
  parameter int                     SYNC_STAGES = 2,
  parameter int                     LOCK_STABLE = 1024,
  parameter int                     SDRAM_WAIT  = 20000,
  parameter int                     CE_COUNT    = 2,
  parameter logic [16*CE_COUNT-1:0] CE_DIV      = {16'd4, 16'd2},
  parameter bit                     CK_INVERT   = 1'b0,
  parameter int                     CNT_W       = 16
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                pllLocked,
  output logic                sdramCkD0,
  output logic                sdramCkD1,
  output logic                sysReset,
  output logic                sdramInit,
  output logic [CE_COUNT-1:0] ce,
  output logic [1:0]          state,
  output logic [7:0]          lossCount
);

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_STAB = 2'd1;
  localparam logic [1:0] S_CKON = 2'd2;
  localparam logic [1:0] S_RUN  = 2'd3;

  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] CKON_LAST = CNT_W'(SDRAM_WAIT - 1);

  // Lock synchronizer; only its last stage is used anywhere below.
  logic [SYNC_STAGES-1:0] lock_sync;
  logic                   lock_s;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) lock_sync <= '0;
    else         lock_sync <= {lock_sync[SYNC_STAGES-2:0], pllLocked};
  end

  assign lock_s = lock_sync[SYNC_STAGES-1];

  logic [1:0]       state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  // State register (the state port is the register itself).
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= S_WAIT;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state. Lock loss is tested before the counter terminal so it wins.
  always_comb begin
    state_next = state;
    cnt_next   = cnt + CNT_W'(1);
    case (state)
      S_WAIT: begin
        cnt_next = '0;
        if (lock_s) state_next = S_STAB;
      end
      S_STAB: begin
        if (!lock_s) begin
          state_next = S_WAIT;
          cnt_next   = '0;
        end else if (cnt == STAB_LAST) begin
          state_next = S_CKON;
          cnt_next   = '0;
        end
      end
      S_CKON: begin
        if (!lock_s) begin
          state_next = S_WAIT;
          cnt_next   = '0;
        end else if (cnt == CKON_LAST) begin
          state_next = S_RUN;
          cnt_next   = '0;
        end
      end
      S_RUN: begin
        cnt_next = '0;
        if (!lock_s) state_next = S_WAIT;
      end
    endcase
  end

  // Output logic: every output is registered, so decode from the next state.
  logic       ck_on_next, d0_next, d1_next, sys_reset_next, init_next, lost;
  logic [7:0] loss_next;

  always_comb begin
    ck_on_next     = (state_next == S_CKON) || (state_next == S_RUN);
    d0_next        = ck_on_next & ~CK_INVERT;
    d1_next        = ck_on_next & CK_INVERT;
    sys_reset_next = (state_next != S_RUN);
    init_next      = (state_next == S_RUN) && (state != S_RUN);
    lost           = ((state == S_CKON) || (state == S_RUN)) && !lock_s;
    loss_next      = lossCount;
    if (lost && (lossCount != 8'hFF)) loss_next = lossCount + 8'd1;
  end

  // Divided enables: counters restart at RUN entry so all channels start in phase.
  logic [CE_COUNT-1:0] ce_next;

  for (genvar k = 0; k < CE_COUNT; k++) begin : g_ce
    localparam logic [15:0] DIV_LAST = CE_DIV[16*k +: 16] - 16'd1;
    logic [15:0] div_cnt, div_cnt_next;

    always_comb begin
      div_cnt_next = '0;
      if ((state_next == S_RUN) && (state == S_RUN))
        div_cnt_next = (div_cnt == DIV_LAST) ? 16'd0 : div_cnt + 16'd1;
    end

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) div_cnt <= '0;
      else         div_cnt <= div_cnt_next;
    end

    assign ce_next[k] = (state_next == S_RUN) && (div_cnt_next == DIV_LAST);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sdramCkD0 <= 1'b0;
      sdramCkD1 <= 1'b0;
      sysReset  <= 1'b1;
      sdramInit <= 1'b0;
      ce        <= '0;
      lossCount <= '0;
    end else begin
      sdramCkD0 <= d0_next;
      sdramCkD1 <= d1_next;
      sysReset  <= sys_reset_next;
      sdramInit <= init_next;
      ce        <= ce_next;
      lossCount <= loss_next;
    end
  end

endmodule
